serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: diff = a - b, computed LSB-first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_fs.sv | 25 ++
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Purpose : shared state encoding and sizing helpers for the bit-serial subtractor.
// Latency : n/a (types and constants only).
// Backpres: n/a.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit counter width. The counter only has to reach WIDTH-1.
  // It is never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Purpose : 1-bit full subtractor (a - b - bin) built from 2:1 muxes and inverters.
// Latency : combinational, zero cycles.
// Backpres: none; pure function of its inputs.
// Ports   : a, b, bin -> d (difference bit), bout (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x;

  // x = a ^ b, written as a mux that selects b or its inverse.
  assign x = a ? ~b : b;

  // d = x ^ bin.
  assign d = x ? ~bin : bin;

  // When the bits differ, a borrow happens exactly when a is 0.
  // When the bits match, the incoming borrow passes straight through.
  assign bout = x ? ~a : bin;

endmodule

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial WIDTH-bit subtractor, diff = a - b mod 2^WIDTH, LSB first.
// Latency : start accepted at edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpres: start is only honoured in IDLE; requests while busy/done are dropped.
// Ports   : clk, rst_n (async, active-low), start, a_in, b_in -> diff, borrow_out,
//           busy (SHIFT state), done (one-cycle pulse in DONE state).
module serial_subtractor #(
  parameter int WIDTH = 4  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  import serial_subtractor_pkg::*;

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fs_d;
  logic             fs_bout;

  // A single cell handles every bit position.
  // The operands shift their next bit into position 0 on each cycle.
  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          bw_d    = 1'b0;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // New difference bits enter at the MSB.
        // After WIDTH shifts the first bit computed has reached bit 0.
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bw_d   = fs_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          borrow_d = fs_bout;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;

  int vectors = 0;
  int errors  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain modular arithmetic on the unsigned operands.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(a - b);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b);
  endfunction

  // Issues one operation and records what the DUT did. Results are returned, not judged.
  // If glitch > 0, start is pulsed with 9/2 on that cycle after the accept.
  // On every other cycle the operand inputs get random values, which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch,
                        output int nbusy, output int done_at, output int ndone,
                        output logic [W-1:0] d, output logic bo);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    nbusy = 0; done_at = -1; ndone = 0; d = '0; bo = 1'b0;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = c;
          d  = diff;
          bo = borrow_out;
        end
      end
      if (c == glitch) begin
        start = 1'b1; a_in = W'(9); b_in = W'(2);
      end else begin
        start = 1'b0; a_in = W'($urandom_range(15)); b_in = W'($urandom_range(15));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (diff !== '0 || borrow_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: diff=%h borrow=%b busy=%b done=%b, required 0/0/0/0",
               diff, borrow_out, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_pairs(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int nb, da, nd;
    logic [W-1:0] d;
    logic bo;
    run_op(a, b, 0, nb, da, nd, d, bo);
    vectors++;
    if (nb !== W || da !== W + 1 || nd !== 1) begin
      errors++;
      $display("FAIL %s_timing a=%0d b=%0d: busy=%0d done_at=%0d ndone=%0d, required %0d/%0d/1",
               tag, a, b, nb, da, nd, W, W + 1);
    end
    vectors++;
    if (d !== ref_diff(a, b) || bo !== ref_borrow(a, b)) begin
      errors++;
      $display("FAIL %s_result a=%0d b=%0d: diff=%h borrow=%b, required %h/%b",
               tag, a, b, d, bo, ref_diff(a, b), ref_borrow(a, b));
    end
  endtask

  task automatic test_directed;
    test_pairs(W'(5),  W'(3),  "dir_5m3");
    test_pairs(W'(3),  W'(5),  "dir_3m5");
    test_pairs(W'(0),  W'(1),  "dir_0m1");
    test_pairs(W'(15), W'(15), "dir_15m15");
    test_pairs(W'(0),  W'(0),  "dir_0m0");
  endtask

  task automatic test_exhaustive;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        test_pairs(W'(a), W'(b), "exh");
  endtask

  task automatic test_start_while_busy;
    int nb, da, nd;
    logic [W-1:0] d;
    logic bo;
    run_op(W'(7), W'(1), 2, nb, da, nd, d, bo);
    vectors++;
    if (d !== W'(6) || bo !== 1'b0 || nd !== 1 || nb !== W) begin
      errors++;
      $display("FAIL busy_start: diff=%h borrow=%b ndone=%0d busy=%0d, required 6/0/1/%0d",
               d, bo, nd, nb, W);
    end
    // The dropped request must not start a second operation.
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || diff !== W'(6)) begin
      errors++;
      $display("FAIL busy_start_hold: busy=%b diff=%h, required 0/6", busy, diff);
    end
  endtask

  task automatic test_reset_abort;
    int nb, da, nd;
    logic [W-1:0] d;
    logic bo;
    bit saw_done;
    // Leave a nonzero result in place so the clear can be observed.
    run_op(W'(3), W'(5), 0, nb, da, nd, d, bo);
    @(negedge clk);
    start = 1'b1; a_in = W'(13); b_in = W'(6);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (diff !== '0 || borrow_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: diff=%h borrow=%b busy=%b done=%b, required 0/0/0/0",
               diff, borrow_out, busy, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (i == 2) rst_n = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done seen=%b, required 0", saw_done);
    end
    test_pairs(W'(8), W'(3), "after_abort");
  endtask

  // Holding start high means an accept on every first edge in IDLE, one every W+2 cycles.
  // Counting negedges m from the one where start is raised:
  //   accepts follow negedges 0, 6, 12, ...
  //   done is high at m % 6 == 5
  //   busy is high at m % 6 in 1..4
  task automatic test_back_to_back;
    localparam int P = W + 2;
    localparam int NOPS = 8;
    logic [W-1:0] op_a [NOPS];
    logic [W-1:0] op_b [NOPS];
    logic exp_busy, exp_done;
    for (int m = 0; m <= NOPS * P; m++) begin
      @(negedge clk);
      if (m > 0) begin
        exp_done = ((m % P) == P - 1);
        exp_busy = ((m % P) >= 1) && ((m % P) <= W);
        vectors++;
        if (busy !== exp_busy || done !== exp_done) begin
          errors++;
          $display("FAIL b2b_flags m=%0d: busy=%b done=%b, required %b/%b",
                   m, busy, done, exp_busy, exp_done);
        end
        if (exp_done) begin
          vectors++;
          if (diff !== ref_diff(op_a[m / P], op_b[m / P]) ||
              borrow_out !== ref_borrow(op_a[m / P], op_b[m / P])) begin
            errors++;
            $display("FAIL b2b_result op=%0d a=%0d b=%0d: diff=%h borrow=%b, required %h/%b",
                     m / P, op_a[m / P], op_b[m / P], diff, borrow_out,
                     ref_diff(op_a[m / P], op_b[m / P]), ref_borrow(op_a[m / P], op_b[m / P]));
          end
        end
      end
      if (m == NOPS * P) begin
        start = 1'b0;
      end else begin
        start = 1'b1;
        a_in  = W'($urandom_range(15));
        b_in  = W'($urandom_range(15));
        if ((m % P) == 0) begin
          op_a[m / P] = a_in;
          op_b[m / P] = b_in;
        end
      end
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_after: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
